// File: rtl/bsg_arb_round_robin_lock_if.sv
// Handshake bundle between the requesters/consumer and the round-robin lock arbiter.
interface bsg_arb_round_robin_lock_if #(
    parameter int width_p    = 32,
    parameter int lg_width_p = $clog2(width_p)
);
    logic [width_p-1:0]    reqs_i;
    logic [width_p-1:0]    grants_o;
    logic [lg_width_p-1:0] tag_o;
    logic                  v_o;
    logic                  yumi_i;
    logic                  locked_o;
    logic                  release_i;

    // Requester / consumer side.
    modport master (
        output reqs_i,
        output yumi_i,
        output release_i,
        input  grants_o,
        input  tag_o,
        input  v_o,
        input  locked_o
    );

    // Arbiter side.
    modport slave (
        input  reqs_i,
        input  yumi_i,
        input  release_i,
        output grants_o,
        output tag_o,
        output v_o,
        output locked_o
    );
endinterface

// File: rtl/bsg_arb_round_robin_lock.sv
// Round-robin arbiter with registered grant offer (valid/yumi) and optional
// grant lock that holds the resource until the holder releases it.
//
// state  | meaning
// IDLE   | no grant outstanding; arbitrate whenever any request is present
// OFFER  | registered winner offered on v_o, held stable until yumi_i
// LOCKED | resource held by tag_o until release_i (lock_p=1 only)
module bsg_arb_round_robin_lock #(
    parameter int width_p    = 32,
    parameter int lg_width_p = $clog2(width_p),
    parameter bit lock_p     = 1'b1
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    bsg_arb_round_robin_lock_if.slave     arb_if
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        OFFER  = 2'd1,
        LOCKED = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [lg_width_p-1:0] ptr_q, ptr_d;
    logic [lg_width_p-1:0] tag_q, tag_d;
    logic [width_p-1:0]    grant_q, grant_d;

    logic [width_p-1:0]    mask_above_ptr;
    logic [width_p-1:0]    reqs_masked;
    logic                  masked_v, unmasked_v;
    logic [lg_width_p-1:0] masked_tag, unmasked_tag;
    logic [lg_width_p-1:0] win_tag;
    logic                  any_req;

    // Lowest set bit of vec; {valid, index}.
    function automatic logic [lg_width_p:0] pri_enc(input logic [width_p-1:0] vec);
        logic                  vld;
        logic [lg_width_p-1:0] idx;
        vld = 1'b0;
        idx = '0;
        for (int k = width_p - 1; k >= 0; k--) begin
            if (vec[k]) begin
                vld = 1'b1;
                idx = lg_width_p'(k);
            end
        end
        return {vld, idx};
    endfunction

    // Winner selection: search starts just above the last accepted winner and wraps.
    always_comb begin
        mask_above_ptr = '0;
        for (int k = 0; k < width_p; k++) begin
            mask_above_ptr[k] = (k > int'(ptr_q));
        end
        reqs_masked                = arb_if.reqs_i & mask_above_ptr;
        {masked_v, masked_tag}     = pri_enc(reqs_masked);
        {unmasked_v, unmasked_tag} = pri_enc(arb_if.reqs_i);
        win_tag                    = masked_v ? masked_tag : unmasked_tag;
        any_req                    = unmasked_v;
    end

    // State and registered grant; reset drops any offer or lock immediately.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            ptr_q   <= lg_width_p'(width_p - 1);
            tag_q   <= '0;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            tag_q   <= tag_d;
            grant_q <= grant_d;
        end
    end

    // Next state, winner capture and pointer update (pointer moves only on yumi).
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        tag_d   = tag_q;
        grant_d = grant_q;
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    tag_d   = win_tag;
                    grant_d = width_p'(1) << win_tag;
                    state_d = OFFER;
                end
            end
            OFFER: begin
                if (arb_if.yumi_i) begin
                    ptr_d   = tag_q;
                    state_d = lock_p ? LOCKED : IDLE;
                end
            end
            LOCKED: begin
                if (arb_if.release_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decode from registered state only; nothing from reqs_i reaches them.
    always_comb begin
        arb_if.v_o      = (state_q == OFFER);
        arb_if.locked_o = (state_q == LOCKED);
        arb_if.grants_o = ((state_q == OFFER) || (state_q == LOCKED)) ? grant_q : '0;
        arb_if.tag_o    = tag_q;
    end

`ifndef SYNTHESIS
    // Consumer must only accept while an offer is valid.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            assert (!(arb_if.yumi_i && (state_q != OFFER)))
                else $error("yumi_i asserted while v_o=0");
        end
    end
`endif

endmodule
